// File: rtl/mem_status_pkg.sv
// Shared types and constants for the memory-mapped completion mailbox responder.
// State encoding, default mailbox addresses and the signature step function.
package mem_status_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TOUT = 3'd4
    } status_state_t;

    localparam logic [31:0] DEF_PASS_ADR    = 32'd100;
    localparam logic [31:0] DEF_PASS_DATA   = 32'd25;
    localparam logic [31:0] DEF_SCRATCH_ADR = 32'd96;
    localparam logic [31:0] DEF_SIG_ADR     = 32'd104;

    localparam int TAP_A = 9;
    localparam int TAP_B = 29;
    localparam int TAP_C = 30;
    localparam int TAP_D = 31;

    // One signature step: fold instruction, PC and any store data, then shift with feedback.
    function automatic logic [31:0] sig_step(
        input logic [31:0] sig,
        input logic [31:0] instr,
        input logic [31:0] pc,
        input logic        wen,
        input logic [31:0] wdata
    );
        logic [31:0] h1;
        h1 = sig ^ instr ^ pc ^ (wen ? wdata : 32'd0);
        return {h1[30:0], h1[TAP_A] ^ h1[TAP_B] ^ h1[TAP_C] ^ h1[TAP_D]};
    endfunction

endpackage

// File: rtl/mem_status_responder_sig_misr.sv
// Signature register (MISR) for mem_status_responder: advances while enabled,
// holds its value once frozen.
module sig_misr
    import mem_status_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        freeze_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        wen_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] sig_o
);

    logic [31:0] sig_q, sig_d;

    always_comb begin
        // NOTE: default first so every path assigns sig_d and no latch is inferred.
        sig_d = sig_q;
        if (en_i && !freeze_i) begin
            sig_d = sig_step(sig_q, instr_i, pc_i, wen_i, wdata_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/mem_status_responder.sv
// Passive completion-mailbox responder on the core's store bus: reports pass/fail/timeout
// and a running signature. Define SIG_READBACK_EN to add signature readback at SIG_ADR.
module mem_status_responder
    import mem_status_pkg::*;
#(
    parameter logic [31:0] PASS_ADR    = DEF_PASS_ADR,
    parameter logic [31:0] PASS_DATA   = DEF_PASS_DATA,
    parameter logic [31:0] SCRATCH_ADR = DEF_SCRATCH_ADR,
    parameter int          TIMEOUT_CYC = 4096
`ifdef SIG_READBACK_EN
    ,
    parameter logic [31:0] SIG_ADR     = DEF_SIG_ADR
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic [31:0] Instr,
    input  logic [31:0] PC,
`ifdef SIG_READBACK_EN
    input  logic [31:0] ReadAdr,
    output logic        rd_hit,
    output logic [31:0] rd_data,
`endif
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timed_out,
    output logic [31:0] signature,
    output logic [15:0] write_count
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    status_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      wcnt_q, wcnt_d;
    logic             done_q, pass_q, fail_q, tout_q;

    logic pass_hit, scratch_hit;
    assign pass_hit    = MemWrite && (DataAdr == PASS_ADR);
    assign scratch_hit = MemWrite && (DataAdr == SCRATCH_ADR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Terminating writes take priority over the timeout on the same edge.
                if (pass_hit && (WriteData == PASS_DATA)) begin
                    state_d = ST_PASS;
                end else if (pass_hit || (MemWrite && !scratch_hit)) begin
                    state_d = ST_FAIL;
                end else begin
                    if (scratch_hit && (wcnt_q != 16'hFFFF)) wcnt_d = wcnt_q + 16'd1;
                    if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) state_d = ST_TOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            done_q  <= (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TOUT);
            pass_q  <= (state_d == ST_PASS);
            fail_q  <= (state_d == ST_FAIL) || (state_d == ST_TOUT);
            tout_q  <= (state_d == ST_TOUT);
        end
    end

    sig_misr u_sig_misr (
        .clk      (clk),
        .reset    (reset),
        .en_i     (state_q == ST_RUN),
        .freeze_i (done_q),
        .instr_i  (Instr),
        .pc_i     (PC),
        .wen_i    (MemWrite),
        .wdata_i  (WriteData),
        .sig_o    (signature)
    );

`ifdef SIG_READBACK_EN
    logic [31:0] rd_data_q;

    assign rd_hit = (ReadAdr == SIG_ADR);

    // Registered to line up with the core's multi-cycle load timing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data_q <= '0;
        else        rd_data_q <= rd_hit ? signature : 32'd0;
    end

    assign rd_data = rd_data_q;
`endif

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timed_out   = tout_q;
    assign write_count = wcnt_q;

endmodule

// File: tb/tb_mem_status_responder.sv
// Scoreboard bench for mem_status_responder (timeout shortened to 16 RUN cycles).
// Each driven cycle pushes the model's expected status; it is popped after the edge.
module tb_mem_status_responder;

    localparam int TB_TIMEOUT = 16;

    logic        clk, reset, start, MemWrite;
    logic [31:0] DataAdr, WriteData, Instr, PC;
    logic        done, pass, fail, timed_out;
    logic [31:0] signature;
    logic [15:0] write_count;
`ifdef SIG_READBACK_EN
    logic [31:0] ReadAdr;
    logic        rd_hit;
    logic [31:0] rd_data;
`endif

    mem_status_responder #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .Instr      (Instr),
        .PC         (PC),
`ifdef SIG_READBACK_EN
        .ReadAdr    (ReadAdr),
        .rd_hit     (rd_hit),
        .rd_data    (rd_data),
`endif
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .timed_out  (timed_out),
        .signature  (signature),
        .write_count(write_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_RUN, M_PASS, M_FAIL, M_TOUT} m_state_t;
    typedef struct {
        logic [31:0] sig;
        logic        done, pass, fail, tout;
        logic [15:0] wc;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    m_state_t    m_state;
    logic [31:0] m_sig;
    int          m_cnt;
    logic [15:0] m_wc;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] model_sig(input logic [31:0] s, input logic [31:0] i,
                                              input logic [31:0] p, input logic w,
                                              input logic [31:0] d);
        logic [31:0] h;
        h = s ^ i ^ p;
        if (w) h = h ^ d;
        return {h[30:0], h[9] ^ h[29] ^ h[30] ^ h[31]};
    endfunction

    function automatic logic [51:0] obs_vec();
        return {signature, done, pass, fail, timed_out, write_count};
    endfunction

    function automatic logic [51:0] exp_vec(input exp_t e);
        return {e.sig, e.done, e.pass, e.fail, e.tout, e.wc};
    endfunction

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; MemWrite = 1'b0;
        DataAdr = '0; WriteData = '0; Instr = '0; PC = '0;
`ifdef SIG_READBACK_EN
        ReadAdr = '0;
`endif
        m_state = M_IDLE; m_sig = '0; m_cnt = 0; m_wc = '0;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // Drive one cycle, advance the model, queue expected post-edge status.
    task automatic step(input logic st, input logic [31:0] instr, input logic [31:0] pc,
                        input logic wen, input logic [31:0] adr, input logic [31:0] wdata);
        exp_t e;
        start = st; Instr = instr; PC = pc; MemWrite = wen; DataAdr = adr; WriteData = wdata;
        e.rd = '0;
`ifdef SIG_READBACK_EN
        if (ReadAdr == 32'd104) e.rd = m_sig;
`endif
        case (m_state)
            M_IDLE: if (st) m_state = M_RUN;
            M_RUN: begin
                m_sig = model_sig(m_sig, instr, pc, wen, wdata);
                if (wen && adr == 32'd100)      m_state = (wdata == 32'd25) ? M_PASS : M_FAIL;
                else if (wen && adr != 32'd96)  m_state = M_FAIL;
                else begin
                    if (wen && m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
                    if (m_cnt == TB_TIMEOUT - 1) m_state = M_TOUT;
                end
                m_cnt++;
            end
            default: ;
        endcase
        e.sig  = m_sig;
        e.done = (m_state == M_PASS) || (m_state == M_FAIL) || (m_state == M_TOUT);
        e.pass = (m_state == M_PASS);
        e.fail = (m_state == M_FAIL) || (m_state == M_TOUT);
        e.tout = (m_state == M_TOUT);
        e.wc   = m_wc;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({done, pass, fail, timed_out, write_count, signature} !== 52'd0) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected 0", {done, pass, fail, timed_out, write_count, signature});
        end
        do_reset();
    endtask

    task automatic test_sig_step();
        exp_t e;
        do_reset();
        step(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (signature !== 32'h26) begin
            n_errors++; $display("FAIL sig_first: got %h expected 00000026", signature);
        end
        step(1'b0, 32'h13, 32'h4, 1'b0, 32'h0, 32'h0);
        n_checks++;
        if (signature !== 32'h62) begin
            n_errors++; $display("FAIL sig_second: got %h expected 00000062", signature);
        end
        step(1'b0, 32'h8000_0200, 32'h8, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h6000_0000, 32'hC, 1'b1, 32'd96, 32'h1234_5678);
        for (int i = 0; i < 3; i++) step(1'b0, $urandom, $urandom, 1'b0, 32'h0, 32'h0);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); n_checks++;
            if (obs_vec() !== exp_vec(e) && sb.size() == 0) begin
                n_errors++; $display("FAIL sig_step_final: got %h expected %h", obs_vec(), exp_vec(e));
            end
        end
    endtask

    task automatic test_pass_path();
        exp_t        e;
        logic [31:0] frozen;
        do_reset();
        step(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        e = sb.pop_front(); n_checks++;
        if (obs_vec() !== exp_vec(e)) begin
            n_errors++; $display("FAIL pass_start: got %h expected %h", obs_vec(), exp_vec(e));
        end
        step(1'b0, 32'h0000_0513, 32'h10, 1'b1, 32'd96, 32'd7);
        step(1'b0, 32'h00A0_2223, 32'h14, 1'b1, 32'd100, 32'd25);
        while (sb.size() > 0) begin
            e = sb.pop_front(); n_checks++;
            if (sb.size() == 0 && obs_vec() !== exp_vec(e)) begin
                n_errors++; $display("FAIL pass_write: got %h expected %h", obs_vec(), exp_vec(e));
            end
        end
        n_checks++;
        if ({done, pass, fail, timed_out, write_count} !== {4'b1100, 16'd1}) begin
            n_errors++;
            $display("FAIL pass_flags: got %b wc=%0d expected 1100 wc=1", {done, pass, fail, timed_out}, write_count);
        end
        frozen = signature;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, $urandom, 1'b1, 32'd200, 32'd3);
            e = sb.pop_front(); n_checks++;
            if (obs_vec() !== exp_vec(e) || signature !== frozen) begin
                n_errors++; $display("FAIL pass_frozen[%0d]: got %h expected %h", i, obs_vec(), exp_vec(e));
            end
        end
    endtask

    task automatic test_fail_paths();
        exp_t e;
        do_reset();
        step(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0000_0033, 32'h20, 1'b1, 32'd100, 32'd26);
        while (sb.size() > 0) e = sb.pop_front();
        n_checks++;
        if ({done, pass, fail, timed_out} !== 4'b1010 || obs_vec() !== exp_vec(e)) begin
            n_errors++; $display("FAIL wrong_data: got %h expected %h", obs_vec(), exp_vec(e));
        end
        do_reset();
        step(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0000_0093, 32'h24, 1'b1, 32'd200, 32'd25);
        while (sb.size() > 0) e = sb.pop_front();
        n_checks++;
        if ({done, pass, fail, timed_out} !== 4'b1010 || obs_vec() !== exp_vec(e)) begin
            n_errors++; $display("FAIL stray_adr: got %h expected %h", obs_vec(), exp_vec(e));
        end
        step(1'b0, 32'h0000_0113, 32'h28, 1'b1, 32'd100, 32'd25);
        e = sb.pop_front(); n_checks++;
        if ({done, pass, fail, timed_out} !== 4'b1010 || obs_vec() !== exp_vec(e)) begin
            n_errors++; $display("FAIL fail_sticky: got %h expected %h", obs_vec(), exp_vec(e));
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        do_reset();
        step(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        void'(sb.pop_front());
        for (int i = 1; i <= TB_TIMEOUT + 2; i++) begin
            step(1'b0, 32'h13 + i, 32'(4 * i), 1'b0, 32'h0, 32'h0);
            e = sb.pop_front(); n_checks++;
            if (obs_vec() !== exp_vec(e)) begin
                n_errors++; $display("FAIL timeout_cyc[%0d]: got %h expected %h", i, obs_vec(), exp_vec(e));
            end
        end
        n_checks++;
        if ({done, pass, fail, timed_out} !== 4'b1011) begin
            n_errors++; $display("FAIL timeout_flags: got %b expected 1011", {done, pass, fail, timed_out});
        end
        do_reset();
        step(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        for (int i = 1; i < TB_TIMEOUT; i++) step(1'b0, 32'h13, 32'(4 * i), 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h13, 32'h40, 1'b1, 32'd100, 32'd25);
        while (sb.size() > 0) e = sb.pop_front();
        n_checks++;
        if ({done, pass, fail, timed_out} !== 4'b1100 || obs_vec() !== exp_vec(e)) begin
            n_errors++; $display("FAIL timeout_pass_wins: got %h expected %h", obs_vec(), exp_vec(e));
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        step(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'd96, 32'h5);
        step(1'b0, 32'h1357_9BDF, 32'h4, 1'b0, 32'h0, 32'h0);
        sb.delete();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({done, pass, fail, timed_out, write_count, signature} !== 52'd0) begin
            n_errors++;
            $display("FAIL async_reset: got %h expected 0", {done, pass, fail, timed_out, write_count, signature});
        end
        do_reset();
        step(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 32'h0);
        while (sb.size() > 0) e = sb.pop_front();
        n_checks++;
        if (signature !== 32'h26 || obs_vec() !== exp_vec(e)) begin
            n_errors++; $display("FAIL restart_sig: got %h expected %h", obs_vec(), exp_vec(e));
        end
    endtask

`ifdef SIG_READBACK_EN
    task automatic test_readback();
        exp_t e;
        do_reset();
        step(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'hABCD_0013, 32'h8, 1'b0, 32'h0, 32'h0);
        sb.delete();
        ReadAdr = 32'd104;
        #1;
        n_checks++;
        if (rd_hit !== 1'b1) begin
            n_errors++; $display("FAIL rd_hit: got %b expected 1", rd_hit);
        end
        step(1'b0, 32'h0000_0213, 32'hC, 1'b0, 32'h0, 32'h0);
        e = sb.pop_front(); n_checks++;
        if (rd_data !== e.rd || obs_vec() !== exp_vec(e)) begin
            n_errors++; $display("FAIL rd_data: got %h expected %h", rd_data, e.rd);
        end
        ReadAdr = 32'd108;
        step(1'b0, 32'h0000_0313, 32'h10, 1'b0, 32'h0, 32'h0);
        e = sb.pop_front(); n_checks++;
        if (rd_hit !== 1'b0 || rd_data !== 32'd0 || obs_vec() !== exp_vec(e)) begin
            n_errors++; $display("FAIL rd_miss: got hit=%b data=%h expected hit=0 data=0", rd_hit, rd_data);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; MemWrite = 1'b0;
        DataAdr = '0; WriteData = '0; Instr = '0; PC = '0;
`ifdef SIG_READBACK_EN
        ReadAdr = '0;
`endif
        test_reset();
        test_sig_step();
        test_pass_path();
        test_fail_paths();
        test_timeout();
        test_async_reset();
`ifdef SIG_READBACK_EN
        test_readback();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_status_responder.md
Name: mem_status_responder

Overview:
- Synthesizable responder on the multi-cycle core's data-memory write port (MemWrite, DataAdr, WriteData).
- Decodes the program's completion mailbox writes and reports pass, fail or timeout.
- Accumulates the same 32-bit Instr/PC/WriteData signature that the simulation checker computes, so FPGA builds self-check without a simulator.
- Sits beside the unified memory inside top; passive on the write bus, never stalls the core.

Parameters:
- PASS_ADR, 32'd100, mailbox address whose write ends the run.
- PASS_DATA, 32'd25, value at PASS_ADR that means success.
- SCRATCH_ADR, 32'd96, address the program may write freely without ending the run.
- TIMEOUT_CYC, 4096, RUN cycles allowed before TIMEOUT.
- SIG_ADR, 32'd104, load address for signature readback (optional feature only).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  level; begins RUN on first high cycle after reset.
- MemWrite  in  1  core store strobe.
- DataAdr  in  32  core data address.
- WriteData  in  32  core store data.
- Instr  in  32  current instruction register of datapath.
- PC  in  32  current PC of datapath.
- done  out  1  high in PASS, FAIL or TOUT.
- pass  out  1  high in PASS only.
- fail  out  1  high in FAIL or TOUT.
- timed_out  out  1  high in TOUT only.
- signature  out  32  running signature.
- write_count  out  16  count of accepted SCRATCH_ADR writes, saturating at 16'hFFFF.
- (SIG_READBACK_EN only) ReadAdr  in  32  core load address.
- (SIG_READBACK_EN only) rd_hit  out  1  load targets SIG_ADR.
- (SIG_READBACK_EN only) rd_data  out  32  readback data.

Behaviour:
- Reset (reset=0, async): state=IDLE; signature=0; cycle counter=0; write_count=0; done, pass, fail, timed_out=0; rd_hit, rd_data=0.
- States: IDLE, RUN, PASS, FAIL, TOUT. Encoding comes from the package.
- IDLE->RUN on clk edge with start=1. No signature update in IDLE.
- RUN, every cycle:
  - h1 = signature ^ Instr ^ PC ^ (MemWrite ? WriteData : 0).
  - signature <= {h1[30:0], h1[9]^h1[29]^h1[30]^h1[31]}.
  - cycle counter increments.
- RUN transitions, evaluated in this priority order on the same edge:
  - MemWrite & DataAdr==PASS_ADR & WriteData==PASS_DATA -> PASS.
  - MemWrite & DataAdr==PASS_ADR & WriteData!=PASS_DATA -> FAIL.
  - MemWrite & DataAdr!=PASS_ADR & DataAdr!=SCRATCH_ADR -> FAIL.
  - MemWrite & DataAdr==SCRATCH_ADR -> stay in RUN, write_count+1.
  - cycle counter==TIMEOUT_CYC-1 with no terminating write -> TOUT.
  - A terminating write on the timeout cycle wins: PASS or FAIL beats TOUT.
- The terminating cycle is folded into the signature. The signature then freezes.
- PASS, FAIL and TOUT are sticky until reset; start is ignored there.
- Outputs are registered and decoded from state: 1-cycle latency from the terminating write edge to done.
- start deasserting in RUN has no effect.
- Reset mid-RUN returns to IDLE and clears everything.
- X/Z inputs are not checked; they must be driven.

Optional Feature:
- Macro SIG_READBACK_EN.
- Defined: ReadAdr, rd_hit and rd_data ports exist.
  - rd_hit = (ReadAdr==SIG_ADR), combinational.
  - rd_data registers {signature} one cycle after rd_hit, so it matches the core's multi-cycle memory read latency.
  - rd_data is 0 when not hit.
  - Reads never alter state.
- Undefined: those ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package mem_status_pkg:
  - status_state_t enum.
  - Default addresses and data: 100, 25, 96, 104.
  - Signature feedback tap constants: 9, 29, 30, 31.
  - function sig_step(sig, instr, pc, wen, wdata).
- One sub-module, sig_misr: holds the signature register, with enable and freeze, and calls sig_step.
- The FSM, counters and decode stay in mem_status_responder.

Test Plan:
- Signature step: reset, start, then Instr=32'h00000013, PC=0, no write -> signature=32'h00000026. Next cycle PC=4, same Instr -> 32'h00000062.
- Pass path: RUN, write 96 with 7, then write 100 with 25 -> write_count=1; next cycle done=1, pass=1, fail=0; signature frozen thereafter.
- Wrong data: write 100 with 26 -> FAIL; done=1, fail=1, pass=0.
- Stray address: write 200 with 25 -> FAIL. A later write 100 with 25 is ignored (sticky).
- Timeout: TIMEOUT_CYC=16, no writes -> TOUT after 16 RUN cycles (timed_out=1, fail=1). Write 100 with 25 on cycle 16 -> PASS instead.
- Async reset mid-RUN: drop reset between edges -> outputs clear immediately. Re-start -> signature restarts from 0. With SIG_READBACK_EN, ReadAdr=104 -> rd_data equals signature one cycle later.
